// File: rtl/header_rx_assembler_if.sv
// Byte-receive and header-publish signals between uart_core, the assembler and minerControl.
// Latency: none, wiring only.
// Backpressure: hdr_ready is a level from the consumer; the byte side has no backpressure.
interface header_rx_assembler_if #(
  parameter int unsigned HDR_BITS = 640
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                hdr_ready;
  logic [HDR_BITS-1:0] block_header;
  logic                header_valid;
  logic                rx_busy;
  logic                frame_error;
  logic [31:0]         byte_count;

  // Byte source / header consumer side.
  modport master (
    output rx_data, rx_valid, hdr_ready,
    input  block_header, header_valid, rx_busy, frame_error, byte_count
  );

  // Assembler side.
  modport slave (
    input  rx_data, rx_valid, hdr_ready,
    output block_header, header_valid, rx_busy, frame_error, byte_count
  );
endinterface

// File: rtl/header_rx_assembler.sv
// Assembles UART bytes into a double-buffered 640-bit block header; optional XOR checksum via HDR_CHECKSUM_EN.
// Latency: header published one cycle after the strobe of the last frame byte.
// Backpressure: none on bytes; a byte arriving while an unaccepted header is held is dropped with frame_error.
module header_rx_assembler #(
  parameter int unsigned HEADER_BYTES   = 80,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input logic                   clock,
  input logic                   reset,
  header_rx_assembler_if.slave  bus
);

  localparam int unsigned HDR_BITS = 8 * HEADER_BYTES;
  localparam int unsigned IDX_W    = $clog2(HEADER_BYTES + 2);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_PAYLOAD = IDX_W'(HEADER_BYTES);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HDR_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [HDR_BITS-1:0] block_header_q, block_header_d;
  logic                header_valid_q, header_valid_d;
  logic                rx_busy_q, rx_busy_d;
  logic                frame_error_q, frame_error_d;
  logic [31:0]         byte_count_q, byte_count_d;
`ifdef HDR_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
  logic [7:0]          chk_base;
`endif

  logic                start_byte;
  logic                cont_byte;
  logic [IDX_W-1:0]    idx_base;
  logic [HDR_BITS+7:0] shreg_ext;

  // Next-state, shift register, publish and error decisions.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    idx_d          = idx_q;
    to_cnt_d       = to_cnt_q;
    block_header_d = block_header_q;
    header_valid_d = header_valid_q;
    frame_error_d  = 1'b0;
    byte_count_d   = byte_count_q;
    start_byte     = 1'b0;
    cont_byte      = 1'b0;
    idx_base       = '0;
    shreg_ext      = {shreg_q, bus.rx_data};
`ifdef HDR_CHECKSUM_EN
    chk_d          = chk_q;
    chk_base       = '0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) start_byte = 1'b1;
      end
      RECV: begin
        if (bus.rx_valid) begin
          cont_byte = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          // Sender went quiet mid-frame: drop the partial frame.
          state_d       = IDLE;
          idx_d         = '0;
          to_cnt_d      = '0;
          frame_error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.hdr_ready) begin
          header_valid_d = 1'b0;
          state_d        = IDLE;
          // A byte coinciding with the accept opens the next frame.
          if (bus.rx_valid) start_byte = 1'b1;
        end else if (bus.rx_valid) begin
          // Overrun: published header still unaccepted, byte is lost.
          frame_error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cont_byte) begin
      idx_base = idx_q;
`ifdef HDR_CHECKSUM_EN
      chk_base = chk_q;
`endif
    end

    if (start_byte || cont_byte) begin
      byte_count_d = byte_count_q + 32'd1;
      to_cnt_d     = '0;
`ifdef HDR_CHECKSUM_EN
      if (idx_base == IDX_PAYLOAD) begin
        // Trailing checksum byte: never shifted into the header.
        idx_d = '0;
        chk_d = '0;
        if (bus.rx_data == chk_base) begin
          block_header_d = shreg_q;
          header_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end
      end else begin
        shreg_d = shreg_ext[HDR_BITS-1:0];
        chk_d   = chk_base ^ bus.rx_data;
        idx_d   = idx_base + 1'b1;
        state_d = RECV;
      end
`else
      shreg_d = shreg_ext[HDR_BITS-1:0];
      if (idx_base + 1'b1 == IDX_PAYLOAD) begin
        block_header_d = shreg_ext[HDR_BITS-1:0];
        header_valid_d = 1'b1;
        idx_d          = '0;
        state_d        = DONE;
      end else begin
        idx_d   = idx_base + 1'b1;
        state_d = RECV;
      end
`endif
    end

    rx_busy_d = (state_d == RECV);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      idx_q          <= '0;
      to_cnt_q       <= '0;
      block_header_q <= '0;
      header_valid_q <= 1'b0;
      rx_busy_q      <= 1'b0;
      frame_error_q  <= 1'b0;
      byte_count_q   <= '0;
`ifdef HDR_CHECKSUM_EN
      chk_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      idx_q          <= idx_d;
      to_cnt_q       <= to_cnt_d;
      block_header_q <= block_header_d;
      header_valid_q <= header_valid_d;
      rx_busy_q      <= rx_busy_d;
      frame_error_q  <= frame_error_d;
      byte_count_q   <= byte_count_d;
`ifdef HDR_CHECKSUM_EN
      chk_q          <= chk_d;
`endif
    end
  end

  assign bus.block_header = block_header_q;
  assign bus.header_valid = header_valid_q;
  assign bus.rx_busy      = rx_busy_q;
  assign bus.frame_error  = frame_error_q;
  assign bus.byte_count   = byte_count_q;

endmodule

// File: tb/tb_header_rx_assembler.sv
// Directed bench for header_rx_assembler: publish, timeout, overrun, mid-frame reset, checksum, count wrap.
module tb_header_rx_assembler;

  localparam logic [639:0] HDR_A = 640'h01000000_81cd02ab_7e569e8b_cd9317e2_fe99f2de_44d49ab2_b8851ba4_a3080000_00000000_e320b6c2_fffc8d75_0423db8b_1eb942ae_710e951e_d797f7af_fc8892b0_f1fc122b_c7f5d74d_f2b9441a_42a14695;
  localparam logic [639:0] HDR_B = ~HDR_A;
`ifdef HDR_CHECKSUM_EN
  localparam int FRAME_BYTES = 81;
`else
  localparam int FRAME_BYTES = 80;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  header_rx_assembler_if #(.HDR_BITS(640)) bus ();

  header_rx_assembler #(.HEADER_BYTES(80), .TIMEOUT_CYCLES(100)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] hbyte(input logic [639:0] h, input int i);
    return h[639-8*i -: 8];
  endfunction

  function automatic logic [7:0] hxor(input logic [639:0] h);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 80; i++) x ^= h[639-8*i -: 8];
    return x;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_payload(input logic [639:0] h, input int first, input int count, input int gap);
    for (int i = first; i < first + count; i++) send_byte(hbyte(h, i), gap);
  endtask

  task automatic send_frame(input logic [639:0] h, input int gap);
    send_payload(h, 0, 80, gap);
`ifdef HDR_CHECKSUM_EN
    send_byte(hxor(h), gap);
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.hdr_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.block_header !== 640'd0) begin fails++; $display("FAIL reset_header: got %h want 0", bus.block_header); end
    checks++; if (bus.header_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.header_valid); end
    checks++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.rx_busy); end
    checks++; if (bus.frame_error !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", bus.frame_error); end
    checks++; if (bus.byte_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.byte_count); end
  endtask

  task automatic test_publish();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < FRAME_BYTES; i++) begin
      b = (i < 80) ? hbyte(HDR_A, i) : hxor(HDR_A);
      if (i == FRAME_BYTES - 1) begin
        checks++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL pub_busy_last: got %b want 1", bus.rx_busy); end
        checks++; if (bus.block_header !== 640'd0) begin fails++; $display("FAIL pub_no_partial: got %h want 0", bus.block_header); end
        checks++; if (bus.header_valid !== 1'b0) begin fails++; $display("FAIL pub_valid_early: got %b want 0", bus.header_valid); end
      end
      send_byte(b, 0);
      if (i == 0) begin
        checks++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL pub_busy_first: got %b want 1", bus.rx_busy); end
      end
      if (i != FRAME_BYTES - 1) repeat (3) @(negedge clock);
    end
    checks++; if (bus.header_valid !== 1'b1) begin fails++; $display("FAIL pub_valid: got %b want 1", bus.header_valid); end
    checks++; if (bus.block_header !== HDR_A) begin fails++; $display("FAIL pub_header: got %h want %h", bus.block_header, HDR_A); end
    checks++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL pub_busy_after: got %b want 0", bus.rx_busy); end
    checks++; if (bus.byte_count !== FRAME_BYTES) begin fails++; $display("FAIL pub_count: got %0d want %0d", bus.byte_count, FRAME_BYTES); end
  endtask

  // Includes a back-to-back (zero-gap) frame after the aborted one.
  task automatic test_timeout_back_to_back();
    int pulses = 0;
    do_reset();
    send_payload(HDR_A, 0, 40, 3);
    checks++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL to_busy_mid: got %b want 1", bus.rx_busy); end
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      if (bus.frame_error === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin fails++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    checks++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", bus.rx_busy); end
    checks++; if (bus.block_header !== 640'd0) begin fails++; $display("FAIL to_header: got %h want 0", bus.block_header); end
    checks++; if (bus.header_valid !== 1'b0) begin fails++; $display("FAIL to_valid: got %b want 0", bus.header_valid); end
    checks++; if (bus.byte_count !== 32'd40) begin fails++; $display("FAIL to_count: got %0d want 40", bus.byte_count); end
    send_frame(HDR_B, 0);
    checks++; if (bus.block_header !== HDR_B) begin fails++; $display("FAIL b2b_header: got %h want %h", bus.block_header, HDR_B); end
    checks++; if (bus.header_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b want 1", bus.header_valid); end
    checks++; if (bus.byte_count !== 40 + FRAME_BYTES) begin fails++; $display("FAIL b2b_count: got %0d want %0d", bus.byte_count, 40 + FRAME_BYTES); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(HDR_A, 1);
    bus.hdr_ready = 1'b0;
    send_byte(8'hEE, 0);
    checks++; if (bus.frame_error !== 1'b1) begin fails++; $display("FAIL ovr_ferr: got %b want 1", bus.frame_error); end
    checks++; if (bus.header_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b want 1", bus.header_valid); end
    checks++; if (bus.byte_count !== FRAME_BYTES) begin fails++; $display("FAIL ovr_count: got %0d want %0d", bus.byte_count, FRAME_BYTES); end
    checks++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL ovr_busy: got %b want 0", bus.rx_busy); end
    @(negedge clock);
    checks++; if (bus.frame_error !== 1'b0) begin fails++; $display("FAIL ovr_ferr_once: got %b want 0", bus.frame_error); end
    bus.hdr_ready = 1'b1;
    send_byte(hbyte(HDR_B, 0), 0);
    bus.hdr_ready = 1'b0;
    checks++; if (bus.header_valid !== 1'b0) begin fails++; $display("FAIL acc_valid: got %b want 0", bus.header_valid); end
    checks++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL acc_busy: got %b want 1", bus.rx_busy); end
    checks++; if (bus.block_header !== HDR_A) begin fails++; $display("FAIL acc_retain: got %h want %h", bus.block_header, HDR_A); end
    checks++; if (bus.byte_count !== FRAME_BYTES + 1) begin fails++; $display("FAIL acc_count: got %0d want %0d", bus.byte_count, FRAME_BYTES + 1); end
    send_payload(HDR_B, 1, 79, 1);
`ifdef HDR_CHECKSUM_EN
    send_byte(hxor(HDR_B), 0);
`endif
    checks++; if (bus.block_header !== HDR_B) begin fails++; $display("FAIL acc_next_header: got %h want %h", bus.block_header, HDR_B); end
    checks++; if (bus.header_valid !== 1'b1) begin fails++; $display("FAIL acc_next_valid: got %b want 1", bus.header_valid); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(HDR_A, 1);
    bus.hdr_ready = 1'b1;
    @(negedge clock);
    bus.hdr_ready = 1'b0;
    checks++; if (bus.header_valid !== 1'b0) begin fails++; $display("FAIL mid_accept: got %b want 0", bus.header_valid); end
    send_payload(HDR_B, 0, 49, 1);
    checks++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", bus.rx_busy); end
    checks++; if (bus.block_header !== HDR_A) begin fails++; $display("FAIL mid_retain: got %h want %h", bus.block_header, HDR_A); end
    checks++; if (bus.byte_count !== FRAME_BYTES + 49) begin fails++; $display("FAIL mid_count: got %0d want %0d", bus.byte_count, FRAME_BYTES + 49); end
    reset = 1'b1;
    send_byte(hbyte(HDR_B, 49), 0);
    checks++; if (bus.block_header !== 640'd0) begin fails++; $display("FAIL rst_header: got %h want 0", bus.block_header); end
    checks++; if (bus.header_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.header_valid); end
    checks++; if (bus.byte_count !== 32'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.byte_count); end
    checks++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bus.rx_busy); end
    reset = 1'b0;
    @(negedge clock);
  endtask

`ifdef HDR_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send_frame(HDR_A, 1);
    checks++; if (bus.block_header !== HDR_A) begin fails++; $display("FAIL chk_header: got %h want %h", bus.block_header, HDR_A); end
    checks++; if (bus.byte_count !== 32'd81) begin fails++; $display("FAIL chk_count: got %0d want 81", bus.byte_count); end
    bus.hdr_ready = 1'b1;
    @(negedge clock);
    bus.hdr_ready = 1'b0;
    send_payload(HDR_B, 0, 80, 1);
    send_byte(hxor(HDR_B) ^ 8'h01, 0);
    checks++; if (bus.frame_error !== 1'b1) begin fails++; $display("FAIL chk_bad_ferr: got %b want 1", bus.frame_error); end
    checks++; if (bus.header_valid !== 1'b0) begin fails++; $display("FAIL chk_bad_valid: got %b want 0", bus.header_valid); end
    checks++; if (bus.block_header !== HDR_A) begin fails++; $display("FAIL chk_bad_header: got %h want %h", bus.block_header, HDR_A); end
    checks++; if (bus.byte_count !== 32'd162) begin fails++; $display("FAIL chk_bad_count: got %0d want 162", bus.byte_count); end
  endtask
`endif

  task automatic test_count_wrap();
    do_reset();
    force dut.byte_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.byte_count_q;
    send_byte(8'h5A, 0);
    checks++; if (bus.byte_count !== 32'd0) begin fails++; $display("FAIL wrap_count: got %h want 0", bus.byte_count); end
    checks++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL wrap_busy: got %b want 1", bus.rx_busy); end
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.hdr_ready = 1'b0;
    test_reset();
    test_publish();
    test_timeout_back_to_back();
    test_overrun();
    test_reset_mid_frame();
`ifdef HDR_CHECKSUM_EN
    test_checksum();
`endif
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
